alu: RTL and testbench

//  32-bit integer ALU for the MIPS32 Harvard datapath (execute stage).

---
 rtl/alu.sv | 117 +++++++++++
 tb/tb_alu.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu -- 32-bit integer ALU for the MIPS32 execute stage.
//
// Computes a 3-bit-selected function of operands a and b. Result and flags
// are registered, giving one clock of latency. result feeds the EX/MEM path
// and zero feeds the branch logic.
//
// Ports:
//   clk       in   1      clock, all state updates on the rising edge
//   rst_n     in   1      asynchronous active-low reset
//   op        in   3      function select
//                         000 AND, 001 OR, 010 ADD, 011 XOR,
//                         100 NOR, 101 SLTU, 110 SUB, 111 SLT
//   a         in   WIDTH  operand A
//   b         in   WIDTH  operand B
//   result    out  WIDTH  registered result
//   zero      out  1      registered flag, set when result is all-zero
//   overflow  out  1      registered signed-overflow flag (ADD/SUB only)
// ---------------------------------------------------------------------------
module alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow
);

  localparam int MSB = WIDTH - 1;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_NOR  = 3'b100;
  localparam logic [2:0] OP_SLTU = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;

  logic [WIDTH-1:0] and_bits;
  logic [WIDTH-1:0] or_bits;
  logic [WIDTH-1:0] xor_bits;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             lt_unsigned;
  logic             lt_signed;

  logic [WIDTH-1:0] result_reg;
  logic [WIDTH-1:0] result_next;
  logic             zero_reg;
  logic             zero_next;
  logic             overflow_reg;
  logic             overflow_next;

  // Bitwise logic functions, one slice per bit.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bitwise
      assign and_bits[gi] = a[gi] & b[gi];
      assign or_bits[gi]  = a[gi] | b[gi];
      assign xor_bits[gi] = a[gi] ^ b[gi];
    end
  endgenerate

  // Carry/borrow are discarded: arithmetic wraps modulo 2^WIDTH.
  assign sum         = a + b;
  assign diff        = a - b;
  assign lt_unsigned = (a < b);
  assign lt_signed   = ($signed(a) < $signed(b));

  always_comb begin
    result_next   = '0;
    overflow_next = 1'b0;
    case (op)
      OP_AND:  result_next = and_bits;
      OP_OR:   result_next = or_bits;
      OP_ADD: begin
        result_next   = sum;
        // Same-sign operands producing a sum of the other sign.
        overflow_next = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      OP_XOR:  result_next = xor_bits;
      OP_NOR:  result_next = ~or_bits;
      OP_SLTU: result_next = {{(WIDTH-1){1'b0}}, lt_unsigned};
      OP_SUB: begin
        result_next   = diff;
        // Opposite-sign operands producing a difference not matching a.
        overflow_next = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
      end
      OP_SLT:  result_next = {{(WIDTH-1){1'b0}}, lt_signed};
      default: result_next = '0;
    endcase
  end

  // zero tracks the value being loaded this edge, not the current result.
  assign zero_next = (result_next == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_reg   <= '0;
      zero_reg     <= 1'b1;
      overflow_reg <= 1'b0;
    end else begin
      result_reg   <= result_next;
      zero_reg     <= zero_next;
      overflow_reg <= overflow_next;
    end
  end

  assign result   = result_reg;
  assign zero     = zero_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_alu.sv
// ---------------------------------------------------------------------------
// tb_alu -- directed self-checking bench for alu.
// ---------------------------------------------------------------------------
module tb_alu;

  localparam int WIDTH = 32;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_NOR  = 3'b100;
  localparam logic [2:0] OP_SLTU = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;

  logic             clk;
  logic             rst_n;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;

  int vec_count  = 0;
  int miss_count = 0;

  alu #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .op       (op),
    .a        (a),
    .b        (b),
    .result   (result),
    .zero     (zero),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [WIDTH-1:0] got,
                     input logic [WIDTH-1:0] exp);
    vec_count++;
    if (got !== exp) begin
      miss_count++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Drive inputs, then sample 1 time unit after the capturing edge.
  task automatic apply(input logic [2:0] op_v, input logic [WIDTH-1:0] a_v,
                       input logic [WIDTH-1:0] b_v, input bit quiet);
    op = op_v;
    a  = a_v;
    b  = b_v;
    @(posedge clk);
    #1;
    if (!quiet)
      $display("op=%b a=%h b=%h -> result=%h zero=%b ovf=%b",
               op_v, a_v, b_v, result, zero, overflow);
  endtask

  initial begin
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] exp_sum;

    rst_n = 1'b0;
    op    = OP_AND;
    a     = '0;
    b     = '0;

    // Reset state while held in reset.
    #12;
    chk("rst_result", result, 32'h0);
    chk("rst_zero", {31'b0, zero}, 32'h1);
    chk("rst_ovf", {31'b0, overflow}, 32'h0);
    rst_n = 1'b1;

    // Mid-cycle asynchronous reset after a nonzero result.
    apply(OP_OR, 32'h0000_00A5, 32'h0000_5A00, 1'b0);
    chk("pre_rst_result", result, 32'h0000_5AA5);
    chk("pre_rst_zero", {31'b0, zero}, 32'h0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_result", result, 32'h0);
    chk("async_rst_zero", {31'b0, zero}, 32'h1);
    chk("async_rst_ovf", {31'b0, overflow}, 32'h0);
    #1;
    rst_n = 1'b1;
    #1;
    chk("rst_hold_result", result, 32'h0);
    chk("rst_hold_zero", {31'b0, zero}, 32'h1);

    // ADD wrap and signed overflow.
    apply(OP_ADD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    chk("add_wrap_result", result, 32'hFFFF_FFFE);
    chk("add_wrap_ovf", {31'b0, overflow}, 32'h0);
    apply(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    chk("add_ovf_result", result, 32'h8000_0000);
    chk("add_ovf_ovf", {31'b0, overflow}, 32'h1);

    // SUB and zero flag.
    apply(OP_SUB, 32'h1234_5678, 32'h1234_5678, 1'b0);
    chk("sub_eq_result", result, 32'h0);
    chk("sub_eq_zero", {31'b0, zero}, 32'h1);
    apply(OP_SUB, 32'h0000_0000, 32'h0000_0001, 1'b0);
    chk("sub_neg_result", result, 32'hFFFF_FFFF);
    chk("sub_neg_zero", {31'b0, zero}, 32'h0);
    chk("sub_neg_ovf", {31'b0, overflow}, 32'h0);
    apply(OP_SUB, 32'h8000_0000, 32'h0000_0001, 1'b0);
    chk("sub_ovf_result", result, 32'h7FFF_FFFF);
    chk("sub_ovf_ovf", {31'b0, overflow}, 32'h1);

    // Signed vs unsigned compare.
    apply(OP_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    chk("slt_result", result, 32'h1);
    chk("slt_zero", {31'b0, zero}, 32'h0);
    apply(OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    chk("sltu_result", result, 32'h0);
    chk("sltu_zero", {31'b0, zero}, 32'h1);
    apply(OP_SLTU, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0);
    chk("sltu_lt_result", result, 32'h1);
    apply(OP_SLT, 32'h0000_0005, 32'h0000_0005, 1'b0);
    chk("slt_eq_result", result, 32'h0);

    // Logic ops.
    apply(OP_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0);
    chk("and_result", result, 32'h00F0_00F0);
    chk("and_ovf", {31'b0, overflow}, 32'h0);
    apply(OP_OR, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0);
    chk("or_result", result, 32'hFFF0_FFF0);
    apply(OP_XOR, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0);
    chk("xor_result", result, 32'hFF00_FF00);
    apply(OP_NOR, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0);
    chk("nor_result", result, 32'h000F_000F);

    // Overflow is cleared by a non-arithmetic op following an overflow.
    apply(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    apply(OP_XOR, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    chk("xor_after_ovf_ovf", {31'b0, overflow}, 32'h0);
    chk("xor_after_ovf_result", result, 32'h7FFF_FFFE);

    // ADD sweep: back-to-back, inputs changed 1 unit after each edge.
    sa = '0;
    sb = '0;
    for (int i = 0; i < 10000; i++) begin
      apply(OP_ADD, sa, sb, 1'b1);
      exp_sum = sa + sb;
      chk("add_sweep", result, exp_sum);
      sa = sa + 32'h2345_6789;
      sb = sb + 32'h3456_7891;
    end
    $display("add sweep: 10000 cycles, last a=%h b=%h", sa, sb);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
